// File: rtl/lcd_pattern_gen_if.sv
// Pixel request/response bus between screen_driver (master) and the
// pattern generator (slave). The driver strobes a request with an x/y
// coordinate and reads the registered RGB565 answer one clock later.
interface lcd_pattern_gen_if;
  logic        pix_req_i;
  logic [15:0] pix_x_i;
  logic [15:0] pix_y_i;
  logic [15:0] pix_data_o;

  modport master (
    output pix_req_i,
    output pix_x_i,
    output pix_y_i,
    input  pix_data_o
  );

  modport slave (
    input  pix_req_i,
    input  pix_x_i,
    input  pix_y_i,
    output pix_data_o
  );
endinterface

// File: rtl/lcd_pattern_gen.sv
// Test-pattern pixel source for screen_driver. Every pixel request is
// answered one clock later with an RGB565 value from one of four patterns:
// colour bars, checkerboard, grey ramp or a bar that moves each frame.
// A debounced push-button queues a pattern change that only takes effect
// at the next frame end, so a frame is never drawn with two patterns.
module lcd_pattern_gen #(
  parameter int SCREEN_WIDTH    = 320,
  parameter int SCREEN_HEIGHT   = 240,
  parameter int CELL_LOG2       = 4,
  parameter int BAR_W           = 16,
  parameter int BAR_STEP        = 4,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic               clk,
  input  logic               rst_n,
  lcd_pattern_gen_if.slave   pix,
  input  logic               mode_btn_n,
  output logic [1:0]         mode_o,
  output logic [7:0]         frame_cnt_o
);

  typedef enum logic [1:0] {
    MODE_BARS    = 2'd0,
    MODE_CHECKER = 2'd1,
    MODE_RAMP    = 2'd2,
    MODE_MOVBAR  = 2'd3
  } modeT;

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [15:0] X_LAST   = 16'(SCREEN_WIDTH - 1);
  localparam logic [15:0] Y_LAST   = 16'(SCREEN_HEIGHT - 1);
  localparam logic [15:0] X_LIMIT  = 16'(SCREEN_WIDTH);
  localparam logic [15:0] Y_LIMIT  = 16'(SCREEN_HEIGHT);
  localparam logic [16:0] W_17     = 17'(SCREEN_WIDTH);
  localparam logic [16:0] BAR_W17  = 17'(BAR_W);
  localparam logic [16:0] STEP_17  = 17'(BAR_STEP);

  // Button synchroniser and debouncer state
  logic            r_btnSync1;
  logic            r_btnSync2;
  logic            r_btnStable;
  logic [DB_W-1:0] r_dbCount;
  logic            w_btnDiffers;
  logic            w_dbDone;
  logic            w_pressEvent;

  // Frame-level state
  modeT            r_mode;
  modeT            w_modeNext;
  logic            r_modePending;
  logic [15:0]     r_barX;
  logic [7:0]      r_frameCnt;

  // Pixel path
  logic [15:0]     r_pixData;
  logic [15:0]     w_pixColour;
  logic            w_inRange;
  logic            w_frameEnd;
  logic [5:0]      w_grey;
  logic            w_checkerOn;
  logic [16:0]     w_x17;
  logic [16:0]     w_bar17;
  logic [16:0]     w_barEnd17;
  logic [16:0]     w_barNext17;

  // Colour-bar lookup: the bar boundaries are i*W/8 rounded down, fixed at
  // elaboration, so the loop collapses to seven constant comparators.
  function automatic logic [15:0] barColour(input logic [15:0] x);
    logic [2:0]  idx;
    int unsigned threshold;
    idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      threshold = i * SCREEN_WIDTH / 8;
      if (32'(x) >= threshold) idx = 3'(i);
    end
    case (idx)
      3'd0:    barColour = 16'hFFFF;
      3'd1:    barColour = 16'hFFE0;
      3'd2:    barColour = 16'h07FF;
      3'd3:    barColour = 16'h07E0;
      3'd4:    barColour = 16'hF81F;
      3'd5:    barColour = 16'hF800;
      3'd6:    barColour = 16'h001F;
      default: barColour = 16'h0000;
    endcase
  endfunction

  // Two-flop synchroniser followed by a level debouncer; the released
  // level (1) is the reset value so a held button is not seen as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btnSync1  <= 1'b1;
      r_btnSync2  <= 1'b1;
      r_btnStable <= 1'b1;
      r_dbCount   <= '0;
    end else begin
      r_btnSync1 <= mode_btn_n;
      r_btnSync2 <= r_btnSync1;
      if (w_btnDiffers) begin
        if (w_dbDone) begin
          r_btnStable <= r_btnSync2;
          r_dbCount   <= '0;
        end else begin
          r_dbCount <= r_dbCount + DB_W'(1);
        end
      end else begin
        r_dbCount <= '0;
      end
    end
  end

  // A press is the cycle in which the stable level falls from 1 to 0.
  always_comb begin
    w_btnDiffers = (r_btnSync2 != r_btnStable);
    w_dbDone     = (r_dbCount == DB_LAST);
    w_pressEvent = w_btnDiffers && w_dbDone && !r_btnSync2;
  end

  // Decode the request coordinate: range check, frame end and the
  // 17-bit operands that keep the moving-bar arithmetic overflow-free.
  always_comb begin
    w_inRange   = (pix.pix_x_i < X_LIMIT) && (pix.pix_y_i < Y_LIMIT);
    w_frameEnd  = pix.pix_req_i && (pix.pix_x_i == X_LAST) && (pix.pix_y_i == Y_LAST);
    w_x17       = {1'b0, pix.pix_x_i};
    w_bar17     = {1'b0, r_barX};
    w_barEnd17  = w_bar17 + BAR_W17;
    w_barNext17 = w_bar17 + STEP_17;
    w_grey      = pix.pix_x_i[5:0];
    w_checkerOn = pix.pix_x_i[CELL_LOG2] ^ pix.pix_y_i[CELL_LOG2];
    w_modeNext  = modeT'(r_mode + 2'd1);
  end

  // Pattern selection for the requested pixel, using the current mode and
  // bar position (a frame-end pixel therefore still uses the old ones).
  always_comb begin
    w_pixColour = 16'h0000;
    if (w_inRange) begin
      case (r_mode)
        MODE_BARS:    w_pixColour = barColour(pix.pix_x_i);
        MODE_CHECKER: w_pixColour = w_checkerOn ? 16'hFFFF : 16'h0000;
        MODE_RAMP:    w_pixColour = {w_grey[5:1], w_grey, w_grey[5:1]};
        MODE_MOVBAR:  w_pixColour = ((w_x17 >= w_bar17) && (w_x17 < w_barEnd17))
                                    ? 16'hF800 : 16'h001F;
        default:      w_pixColour = 16'h0000;
      endcase
    end
  end

  // Register the answer on each request and hold it between requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pixData <= 16'h0000;
    end else if (pix.pix_req_i) begin
      r_pixData <= w_pixColour;
    end
  end

  // Frame-end bookkeeping: count frames, step the bar, apply a queued mode
  // change. A press landing on the frame-end cycle stays queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode        <= MODE_BARS;
      r_modePending <= 1'b0;
      r_barX        <= 16'd0;
      r_frameCnt    <= 8'd0;
    end else begin
      if (w_frameEnd) begin
        r_frameCnt <= r_frameCnt + 8'd1;
        r_barX     <= (w_barNext17 >= W_17) ? 16'd0 : w_barNext17[15:0];
        if (r_modePending) r_mode <= w_modeNext;
      end
      if (w_pressEvent) begin
        r_modePending <= 1'b1;
      end else if (w_frameEnd) begin
        r_modePending <= 1'b0;
      end
    end
  end

  assign pix.pix_data_o = r_pixData;
  assign mode_o         = r_mode;
  assign frame_cnt_o    = r_frameCnt;

endmodule

// File: doc/lcd_pattern_gen.md
Name: lcd_pattern_gen

Overview:
- Pixel source that sits directly upstream of screen_driver.
- Answers each per-pixel request (update strobe plus x/y coordinate) with a registered RGB565 value.
- Four selectable test patterns: colour bars, checkerboard, grey ramp, animated moving bar.
- Pattern selection comes from a debounced push-button; the selection changes only at frame boundaries, so no frame is ever torn.

Parameters:
- SCREEN_WIDTH, 320, active pixels per line; the x range is 0..W-1.
- SCREEN_HEIGHT, 240, active lines per frame; the y range is 0..H-1.
- CELL_LOG2, 4, checkerboard cell size is 2^CELL_LOG2 pixels.
- BAR_W, 16, moving-bar width in pixels.
- BAR_STEP, 4, moving-bar advance in pixels per frame.
- DEBOUNCE_CYCLES, 500_000, stable clk cycles required to accept a button level.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- pix_req_i  in  1  one-cycle strobe from screen_driver requesting the pixel at pix_x_i/pix_y_i.
- pix_x_i  in  16  requested x coordinate; sampled only when pix_req_i=1.
- pix_y_i  in  16  requested y coordinate; sampled only when pix_req_i=1.
- mode_btn_n  in  1  raw asynchronous push-button, active-low.
- pix_data_o  out  16  RGB565 pixel data (R[15:11] G[10:5] B[4:0]).
- mode_o  out  2  currently displayed pattern.
- frame_cnt_o  out  8  completed-frame counter.

Behaviour:
- Reset: clk is the clock and rst_n the reset; rst_n is asynchronous, active-low. On reset:
  - pix_data_o=16'h0000, mode_o=0, frame_cnt_o=0.
  - bar_x=0, mode_pending=0.
  - Debounce sync FFs, stable level and counter reset to released (1).
  - Reset asserted mid-frame aborts everything; the next request is served with mode 0.
- Latency: pix_data_o updates exactly 1 clk after a cycle with pix_req_i=1 and reflects that cycle's x/y. It holds its value otherwise.
- Out-of-range request (x>=W or y>=H): pix_data_o=16'h0000; no frame-end effects.
- Mode 0, colour bars:
  - 8 vertical bars; bar index i applies when T(i) <= x < T(i+1), with T(i)=i*W/8 (elaboration-time constants, floor).
  - Colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- Mode 1, checkerboard: bit0 of ((x>>CELL_LOG2) ^ (y>>CELL_LOG2)) = 1 gives FFFF, else 0000.
- Mode 2, grey ramp:
  - g = x[5:0]; output {g[5:1], g, g[5:1]}.
  - The ramp repeats every 64 pixels.
- Mode 3, moving bar:
  - F800 where bar_x <= x < bar_x+BAR_W, else 001F.
  - Compare in 17 bits so bar_x+BAR_W cannot overflow; the bar is clipped at the right edge.
- Frame end is a request with x=W-1 and y=H-1. In the same cycle:
  - frame_cnt increments (255 wraps to 0).
  - bar_x <= (bar_x+BAR_STEP >= W) ? 0 : bar_x+BAR_STEP.
  - If mode_pending=1: mode <= mode+1 (3 wraps to 0) and mode_pending clears.
  - The frame-end pixel itself is rendered with the old mode and old bar_x.
- Debounce:
  - 2-FF synchroniser on mode_btn_n.
  - The counter increments while the synchronised level differs from the stable level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable level takes the new value and the counter clears.
  - A stable 1->0 transition is a press event (one-cycle pulse).
- Press handling:
  - A press event sets mode_pending.
  - Multiple presses within one frame give a single advance.
  - A press on the same cycle as frame end is not applied at that frame end; it leaves mode_pending=1 for the next frame end.
- Requests arriving back-to-back (pix_req_i high on consecutive cycles) are served each cycle; there is no throughput limit.

Test Plan:
- Reset, then requests at (0,0), (40,0), (280,5), (319,239), W=320 → pix_data_o 1 cycle later = FFFF, FFE0, 0000, 0000; frame_cnt_o=1 after the last request.
- Hold mode_btn_n=0 for DEBOUNCE_CYCLES+4 cycles (bench DEBOUNCE_CYCLES=8) mid-frame → mode_o stays 0 until the frame-end request, then becomes 1; request (16,0) next frame → FFFF, (16,16) → 0000.
- Three 12-cycle button presses within one frame in mode 3 → mode_o becomes 0 (single advance, wrap) at frame end.
- Mode 3, run 80 full frames (bench W=320) → bar_x sequence 0,4,...,316,0; at bar_x=312, request (319,y) → F800 (clipped bar) and (311,y) → 001F.
- Request (320,0) and (0,240) → 0000, frame_cnt_o unchanged; 256 frame ends → frame_cnt_o wraps to 0.
- Assert rst_n for 1 cycle mid-frame in mode 2 with mode_pending=1 → all outputs 0, mode 0 on the next request, pending cleared.
